// File: rtl/sau_pkg.sv
// Shared types and constants for the shift-add DCT-II constant-multiplier unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sau_pkg;

  localparam int SAU_LANES = 8;

  typedef enum logic [1:0] {
    SAU_ODD16 = 2'd0,
    SAU_ODD8  = 2'd1,
    SAU_EVEN4 = 2'd2,
    SAU_RSVD  = 2'd3
  } sau_mode_e;

  // Coefficient table indexed [mode][lane]; the datapath builds these from
  // shifts and adds, the table is the arithmetic reference.
  localparam int SAU_COEF [4][8] = '{
    '{90, 87, 80, 70, 57, 43, 25, 9},
    '{89, 75, 50, 18,  0,  0,  0, 0},
    '{64, 83, 36,  0,  0,  0,  0, 0},
    '{ 0,  0,  0,  0,  0,  0,  0, 0}
  };

endpackage

// File: rtl/sau_odd_pipe_if.sv
// Sample-in / products-out handshake bundle for sau_odd_pipe.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both sides; slave is the multiplier unit.
interface sau_odd_pipe_if #(
  parameter int IN_W  = 11,
  parameter int OUT_W = 20
);
  import sau_pkg::*;

  logic                                in_valid;
  logic                                in_ready;
  logic signed [IN_W-1:0]              in_x;
  logic [1:0]                          in_mode;
  logic                                out_valid;
  logic                                out_ready;
  logic [SAU_LANES-1:0][OUT_W-1:0]     out_p;
  logic [1:0]                          out_mode;

  modport master (
    output in_valid, in_x, in_mode, out_ready,
    input  in_ready, out_valid, out_p, out_mode
  );

  modport slave (
    input  in_valid, in_x, in_mode, out_ready,
    output in_ready, out_valid, out_p, out_mode
  );

endinterface

// File: rtl/sau_coef_net.sv
// Combinational shift/add lane network: shared partial terms + mode -> 8 lane products.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing pipeline owns the handshake.
module sau_coef_net
  import sau_pkg::*;
#(
  parameter int OUT_W = 20
) (
  input  logic signed [OUT_W-1:0]          x_i,
  input  logic signed [OUT_W-1:0]          x3_i,
  input  logic signed [OUT_W-1:0]          x5_i,
  input  logic signed [OUT_W-1:0]          x9_i,
  input  logic signed [OUT_W-1:0]          x35_i,
  input  sau_mode_e                        mode_i,
  output logic [SAU_LANES-1:0][OUT_W-1:0]  lane_o
);

  logic signed [OUT_W-1:0] p90, p87, p80, p70, p57, p43, p25, p9;
  logic signed [OUT_W-1:0] p89, p75, p50, p18;
  logic signed [OUT_W-1:0] p64, p83, p36;

  // ODD16 set
  assign p90 = (x5_i <<< 4) + (x5_i <<< 1);   // 80x + 10x
  assign p87 = (x3_i <<< 5) - x9_i;           // 96x - 9x
  assign p80 = x5_i <<< 4;
  assign p70 = x35_i <<< 1;
  assign p57 = (x3_i <<< 4) + x9_i;           // 48x + 9x
  assign p43 = x35_i + (x_i <<< 3);           // 35x + 8x
  assign p25 = (x5_i <<< 2) + x5_i;           // 20x + 5x
  assign p9  = x9_i;

  // ODD8 set
  assign p89 = (x5_i <<< 4) + x9_i;           // 80x + 9x
  assign p75 = (x5_i <<< 4) - x5_i;           // 80x - 5x
  assign p50 = (x5_i <<< 3) + (x5_i <<< 1);   // 40x + 10x
  assign p18 = x9_i <<< 1;

  // EVEN4 set
  assign p64 = x_i <<< 6;
  assign p83 = (x5_i <<< 4) + x3_i;           // 80x + 3x
  assign p36 = x9_i <<< 2;

  // Route the mode's products onto the lanes; unused lanes and reserved mode read 0
  always_comb begin
    lane_o = '0;
    case (mode_i)
      SAU_ODD16: begin
        lane_o[0] = p90;
        lane_o[1] = p87;
        lane_o[2] = p80;
        lane_o[3] = p70;
        lane_o[4] = p57;
        lane_o[5] = p43;
        lane_o[6] = p25;
        lane_o[7] = p9;
      end
      SAU_ODD8: begin
        lane_o[0] = p89;
        lane_o[1] = p75;
        lane_o[2] = p50;
        lane_o[3] = p18;
      end
      SAU_EVEN4: begin
        lane_o[0] = p64;
        lane_o[1] = p83;
        lane_o[2] = p36;
      end
      default: begin
        lane_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/sau_odd_pipe.sv
// Two-stage shift-add DCT-II constant multiplier (one sample x mode coefficient set); optional rounding via SAU_ROUND_EN.
// Latency: 2 cycles from input transfer to out_valid; 1 sample/cycle throughput.
// Backpressure: skid-free valid/ready, 2 samples in flight; in_ready is combinational from out_ready.
module sau_odd_pipe
  import sau_pkg::*;
#(
  parameter int IN_W  = 11,
  parameter int OUT_W = 20,
  parameter int SHIFT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  sau_odd_pipe_if.slave bus
);

  // Widths below IN_W+7 would overflow the 96x intermediate term
  if (OUT_W < IN_W + 7) begin : g_bad_out_w
    $error("sau_odd_pipe: OUT_W must be at least IN_W+7");
  end
  if (SHIFT < 0 || SHIFT >= OUT_W) begin : g_bad_shift
    $error("sau_odd_pipe: SHIFT out of range");
  end

  logic s1_adv, s2_adv;

  logic                    s1_valid_q, s1_valid_d;
  sau_mode_e               s1_mode_q,  s1_mode_d;
  logic signed [OUT_W-1:0] x_q,   x_d;
  logic signed [OUT_W-1:0] x3_q,  x3_d;
  logic signed [OUT_W-1:0] x5_q,  x5_d;
  logic signed [OUT_W-1:0] x9_q,  x9_d;
  logic signed [OUT_W-1:0] x35_q, x35_d;

  logic                             s2_valid_q, s2_valid_d;
  sau_mode_e                        out_mode_q, out_mode_d;
  logic [SAU_LANES-1:0][OUT_W-1:0]  out_p_q,    out_p_d;

  logic signed [OUT_W-1:0] x_ext, x3_ext, x5_ext, x9_ext, x35_ext;
  logic [SAU_LANES-1:0][OUT_W-1:0] lane_raw, lane_fin;

  // Handshake: a stage advances when it is empty or its consumer advances
  assign s2_adv       = !s2_valid_q || bus.out_ready;
  assign s1_adv       = !s1_valid_q || s2_adv;
  assign bus.in_ready = s1_adv;

  // Sign-extend before any shift so the partial terms cannot overflow
  assign x_ext   = OUT_W'(bus.in_x);
  assign x3_ext  = (x_ext <<< 1) + x_ext;
  assign x5_ext  = (x_ext <<< 2) + x_ext;
  assign x9_ext  = (x_ext <<< 3) + x_ext;
  assign x35_ext = (x_ext <<< 5) + x3_ext;

  sau_coef_net #(
    .OUT_W (OUT_W)
  ) u_coef_net (
    .x_i    (x_q),
    .x3_i   (x3_q),
    .x5_i   (x5_q),
    .x9_i   (x9_q),
    .x35_i  (x35_q),
    .mode_i (s1_mode_q),
    .lane_o (lane_raw)
  );

`ifdef SAU_ROUND_EN
  if (SHIFT > 0) begin : g_round
    localparam logic signed [OUT_W-1:0] HALF = {{(OUT_W-1){1'b0}}, 1'b1} << (SHIFT - 1);
    // Add half an output LSB, then floor with an arithmetic shift
    always_comb begin
      lane_fin = '0;
      for (int i = 0; i < SAU_LANES; i++) begin
        lane_fin[i] = ($signed(lane_raw[i]) + HALF) >>> SHIFT;
      end
    end
  end else begin : g_no_round
    assign lane_fin = lane_raw;
  end
`else
  assign lane_fin = lane_raw;
`endif

  // Next-state for both stages; payload registers move only on a real transfer
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    x_d        = x_q;
    x3_d       = x3_q;
    x5_d       = x5_q;
    x9_d       = x9_q;
    x35_d      = x35_q;
    s2_valid_d = s2_valid_q;
    out_mode_d = out_mode_q;
    out_p_d    = out_p_q;

    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_mode_d = sau_mode_e'(bus.in_mode);
        x_d       = x_ext;
        x3_d      = x3_ext;
        x5_d      = x5_ext;
        x9_d      = x9_ext;
        x35_d     = x35_ext;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_mode_d = s1_mode_q;
        out_p_d    = lane_fin;
      end
    end
  end

  // Pipeline registers; reset drops anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= SAU_ODD16;
      x_q        <= '0;
      x3_q       <= '0;
      x5_q       <= '0;
      x9_q       <= '0;
      x35_q      <= '0;
      s2_valid_q <= 1'b0;
      out_mode_q <= SAU_ODD16;
      out_p_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      x_q        <= x_d;
      x3_q       <= x3_d;
      x5_q       <= x5_d;
      x9_q       <= x9_d;
      x35_q      <= x35_d;
      s2_valid_q <= s2_valid_d;
      out_mode_q <= out_mode_d;
      out_p_q    <= out_p_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_p     = out_p_q;
  assign bus.out_mode  = out_mode_q;

endmodule

// File: tb/tb_sau_odd_pipe.sv
// Directed bench for sau_odd_pipe: coefficient sets, sign handling, backpressure, mid-flight reset.
// Latency: expects 2-cycle input-to-output latency.
// Backpressure: exercises out_ready stalls and combinational in_ready.
module tb_sau_odd_pipe;
  import sau_pkg::*;

  localparam int IN_W  = 11;
  localparam int OUT_W = 20;
`ifdef SAU_ROUND_EN
  localparam int SH = 4;
`else
  localparam int SH = 0;
`endif

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  sau_odd_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  sau_odd_pipe #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint lane_val(input int l);
    return longint'($signed(bus.out_p[l]));
  endfunction

  // Expected product for the configured build (rounded when SH > 0)
  function automatic longint exp_p(input int x, input int m, input int l);
    longint p;
    p = longint'(SAU_COEF[m][l]) * longint'(x);
    if (SH > 0) p = (p + (longint'(1) <<< (SH - 1))) >>> SH;
    return p;
  endfunction

  task automatic chk_out(input string tag, input int m, input longint e[8]);
    chk({tag, "_valid"}, longint'(bus.out_valid), 1);
    chk({tag, "_mode"}, longint'(bus.out_mode), longint'(m));
    for (int l = 0; l < SAU_LANES; l++) begin
      chk($sformatf("%s_lane%0d", tag, l), lane_val(l), e[l]);
    end
  endtask

  // One isolated transaction with out_ready high; garbage on the idle input
  task automatic send_one(input string tag, input int x, input int m, input longint e[8]);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_x      = IN_W'(x);
    bus.in_mode   = 2'(m);
    tick();
    bus.in_valid  = 1'b0;
    bus.in_x      = IN_W'($urandom);
    bus.in_mode   = 2'($urandom);
    chk({tag, "_lat1_valid"}, longint'(bus.out_valid), 0);
    tick();
    chk_out(tag, m, e);
    tick();
    chk({tag, "_drained"}, longint'(bus.out_valid), 0);
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_mode   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_mode", longint'(bus.out_mode), 0);
    chk("rst_lane0", lane_val(0), 0);
    chk("rst_lane7", lane_val(7), 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", longint'(bus.in_ready), 1);

    // Directed coefficient vectors
`ifdef SAU_ROUND_EN
    send_one("r_m0_x1", 1, 0, '{6, 5, 5, 4, 4, 3, 2, 1});
    send_one("r_m0_xm1", -1, 0, '{-6, -5, -5, -4, -4, -3, -2, -1});
    send_one("r_m1_x2", 2, 1, '{11, 9, 6, 2, 0, 0, 0, 0});
    send_one("r_m3_x5", 5, 3, '{0, 0, 0, 0, 0, 0, 0, 0});
`else
    send_one("m0_x1", 1, 0, '{90, 87, 80, 70, 57, 43, 25, 9});
    send_one("m0_xm1024", -1024, 0,
             '{-92160, -89088, -81920, -71680, -58368, -44032, -25600, -9216});
    send_one("m0_x1023", 1023, 0,
             '{92070, 89001, 81840, 71610, 58311, 43989, 25575, 9207});
    send_one("m1_x2", 2, 1, '{178, 150, 100, 36, 0, 0, 0, 0});
    send_one("m2_xm3", -3, 2, '{-192, -249, -108, 0, 0, 0, 0, 0});
    send_one("m3_x5", 5, 3, '{0, 0, 0, 0, 0, 0, 0, 0});
`endif

    // Back-to-back stream, out_ready high: one result per cycle
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_x      = IN_W'(4);
    bus.in_mode   = 2'd0;
    tick();
    chk("str_in_ready0", longint'(bus.in_ready), 1);
    bus.in_x    = IN_W'(5);
    bus.in_mode = 2'd1;
    tick();
    chk("str_o0_valid", longint'(bus.out_valid), 1);
    chk("str_o0_mode", longint'(bus.out_mode), 0);
    chk("str_o0_lane1", lane_val(1), exp_p(4, 0, 1));
    bus.in_x    = IN_W'(6);
    bus.in_mode = 2'd2;
    tick();
    bus.in_valid = 1'b0;
    chk("str_o1_valid", longint'(bus.out_valid), 1);
    chk("str_o1_mode", longint'(bus.out_mode), 1);
    chk("str_o1_lane1", lane_val(1), exp_p(5, 1, 1));
    tick();
    chk("str_o2_valid", longint'(bus.out_valid), 1);
    chk("str_o2_mode", longint'(bus.out_mode), 2);
    chk("str_o2_lane1", lane_val(1), exp_p(6, 2, 1));
    tick();
    chk("str_idle_valid", longint'(bus.out_valid), 0);

    // Backpressure: samples 1,2,3 with out_ready low for 4 cycles
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_mode   = 2'd0;
    bus.in_x      = IN_W'(1);
    #1;
    chk("bp_rdy_a", longint'(bus.in_ready), 1);
    tick();
    bus.in_x = IN_W'(2);
    chk("bp_rdy_b", longint'(bus.in_ready), 1);
    tick();
    bus.in_x = IN_W'(3);
    chk("bp_rdy_full", longint'(bus.in_ready), 0);
    chk("bp_hold0_valid", longint'(bus.out_valid), 1);
    chk("bp_hold0_lane0", lane_val(0), exp_p(1, 0, 0));
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("bp_stall%0d_rdy", c), longint'(bus.in_ready), 0);
      chk($sformatf("bp_stall%0d_lane0", c), lane_val(0), exp_p(1, 0, 0));
      chk($sformatf("bp_stall%0d_lane7", c), lane_val(7), exp_p(1, 0, 7));
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_rdy_comb", longint'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_drain2_valid", longint'(bus.out_valid), 1);
    chk("bp_drain2_lane0", lane_val(0), exp_p(2, 0, 0));
    tick();
    chk("bp_drain3_valid", longint'(bus.out_valid), 1);
    chk("bp_drain3_lane0", lane_val(0), exp_p(3, 0, 0));
    tick();
    chk("bp_empty_valid", longint'(bus.out_valid), 0);

    // Reset with two samples in flight
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_mode   = 2'd1;
    bus.in_x      = IN_W'(7);
    tick();
    bus.in_x = IN_W'(8);
    tick();
    bus.in_valid = 1'b0;
    chk("mid_pre_valid", longint'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", longint'(bus.out_valid), 0);
    chk("mid_rst_lane0", lane_val(0), 0);
    chk("mid_rst_mode", longint'(bus.out_mode), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rel_rdy", longint'(bus.in_ready), 1);
    chk("mid_rel_valid", longint'(bus.out_valid), 0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("mid_stale%0d_valid", c), longint'(bus.out_valid), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
